// File: rtl/mem_arbiter_if.sv
// Purpose: bundles the fetch port, the data port and the single-port memory bus of mem_arbiter.
// Ports: if_* = fetch read port, dm_* = data read/write port, mem_* = memory bus, busy = arbiter status.
// The slave modport is the arbiter's view. The master modport is the requesters' and memory's view.
interface mem_arbiter_if;
  // fetch port
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  // data port
  logic        dm_req;
  logic        dm_we;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  // memory bus
  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  // status
  logic        busy;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_be, dm_addr, dm_wdata, mem_rdata,
    output if_ack, if_rdata, dm_ack, dm_rdata,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_be, dm_addr, dm_wdata, mem_rdata,
    input  if_ack, if_rdata, dm_ack, dm_rdata,
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Purpose: arbitrates a fetch port and a data port onto one single-port memory, one transfer at a time.
// Latency: the ack arrives 2+MEM_LAT cycles after the request is sampled in IDLE.
// Backpressure: a requester holds req until it sees ack. A tie goes to the port not granted last.
// Ports: clk, rst (async, active-high). bus carries the fetch, data and memory signals (slave modport).
module mem_arbiter #(
  parameter int MEM_LAT = 1  // memory read latency, 1..4 cycles
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic [2:0]  cnt, cnt_nxt;
  logic        pick_dm;   // winner if sampled this cycle: 1 = data, 0 = fetch
  logic        take;      // a request is accepted this cycle
  logic        grant_dm;  // port owning the current transfer
  logic        last_dm;   // port granted last. Reset value is fetch.
  logic        lat_we;
  logic [3:0]  lat_be;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;

  // Winner selection. On a tie, the port not granted last wins.
  always_comb begin
    pick_dm = bus.dm_req;
    if (bus.if_req && bus.dm_req) begin
      pick_dm = ~last_dm;
    end
  end

  assign take = (state == IDLE) && (bus.if_req || bus.dm_req);

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // next state and strobes
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bus.mem_en  = 1'b0;
    bus.mem_we  = 1'b0;
    bus.if_ack  = 1'b0;
    bus.dm_ack  = 1'b0;
    bus.busy    = 1'b1;
    case (state)
      IDLE: begin
        bus.busy = 1'b0;
        if (bus.if_req || bus.dm_req) begin
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        bus.mem_en = 1'b1;
        bus.mem_we = lat_we;
        cnt_nxt    = 3'(MEM_LAT);
        state_nxt  = WAIT;
      end
      WAIT: begin
        // Read data is valid in the cycle where the count is 1.
        cnt_nxt = cnt - 3'd1;
        if (cnt == 3'd1) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        bus.if_ack = ~grant_dm;
        bus.dm_ack = grant_dm;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The memory bus fields come from the latched request.
  // They hold their values until the next request is latched.
  assign bus.mem_be    = lat_be;
  assign bus.mem_addr  = lat_addr;
  assign bus.mem_wdata = lat_wdata;

  // request latch, read-data capture, grant history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_dm     <= 1'b0;
      last_dm      <= 1'b0;
      lat_we       <= 1'b0;
      lat_be       <= 4'h0;
      lat_addr     <= 32'h0;
      lat_wdata    <= 32'h0;
      bus.if_rdata <= 32'h0;
      bus.dm_rdata <= 32'h0;
    end else begin
      if (take) begin
        grant_dm  <= pick_dm;
        // A fetch is always a full-word read.
        lat_we    <= pick_dm & bus.dm_we;
        lat_be    <= pick_dm ? bus.dm_be : 4'hF;
        lat_addr  <= pick_dm ? bus.dm_addr : bus.if_addr;
        lat_wdata <= pick_dm ? bus.dm_wdata : 32'h0;
      end
      if ((state == WAIT) && (cnt == 3'd1)) begin
        if (grant_dm) begin
          // A data write returns zero read data.
          bus.dm_rdata <= lat_we ? 32'h0 : bus.mem_rdata;
        end else begin
          bus.if_rdata <= bus.mem_rdata;
        end
      end
      if (state == RESP) begin
        last_dm <= grant_dm;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose: directed self-checking bench for mem_arbiter with MEM_LAT=1 (b1) and MEM_LAT=3 (b3).
// Latency: inputs change 1 time unit after posedge. Outputs are sampled on negedge. Cycle 0 is the request cycle.
// Backpressure: requesters hold req until ack. The memory model returns data_of(addr) after MEM_LAT cycles.
module tb_mem_arbiter;
  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  mem_arbiter_if b1();
  mem_arbiter_if b3();

  mem_arbiter #(.MEM_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
  mem_arbiter #(.MEM_LAT(3)) dut3 (.clk(clk), .rst(rst), .bus(b3.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : (a ^ 32'hA5A5_0000);
  endfunction

  // Memory models. Read data is valid only in the cycle it is due; otherwise they return garbage.
  always @(posedge clk)
    b1.mem_rdata <= (b1.mem_en && !b1.mem_we) ? data_of(b1.mem_addr) : 32'hBAD0_BAD0;

  logic [31:0] p3_0, p3_1, p3_2;
  always @(posedge clk) begin
    p3_0 <= (b3.mem_en && !b3.mem_we) ? data_of(b3.mem_addr) : 32'hBAD0_BAD0;
    p3_1 <= p3_0;
    p3_2 <= p3_1;
  end
  assign b3.mem_rdata = p3_2;

  task automatic idle_inputs();
    b1.if_req = 0; b1.if_addr = 0; b1.dm_req = 0; b1.dm_we = 0; b1.dm_be = 0;
    b1.dm_addr = 0; b1.dm_wdata = 0;
    b3.if_req = 0; b3.if_addr = 0; b3.dm_req = 0; b3.dm_we = 0; b3.dm_be = 0;
    b3.dm_addr = 0; b3.dm_wdata = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 0;
    #1 rst = 1;
    #1;  // before any clock edge
    n_checks++;
    if ({b1.mem_en, b1.mem_we, b1.if_ack, b1.dm_ack, b1.busy} !== 5'b0) begin
      n_fail++; $display("FAIL reset_strobes got=%b want=00000",
                         {b1.mem_en, b1.mem_we, b1.if_ack, b1.dm_ack, b1.busy});
    end
    n_checks++;
    if ({b1.mem_be, b1.mem_addr, b1.mem_wdata} !== 68'h0) begin
      n_fail++; $display("FAIL reset_membus got=%h want=0", {b1.mem_be, b1.mem_addr, b1.mem_wdata});
    end
    n_checks++;
    if ({b1.if_rdata, b1.dm_rdata} !== 64'h0) begin
      n_fail++; $display("FAIL reset_rdata got=%h want=0", {b1.if_rdata, b1.dm_rdata});
    end
    n_checks++;
    if ({b3.busy, b3.mem_en, b3.dm_ack} !== 3'b0) begin
      n_fail++; $display("FAIL reset_lat3 got=%b want=000", {b3.busy, b3.mem_en, b3.dm_ack});
    end
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
  endtask

  task automatic test_fetch();
    @(posedge clk); #1;
    b1.if_req = 1; b1.if_addr = 32'h100;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_checks++;
      if ({b1.mem_en, b1.if_ack, b1.dm_ack, b1.busy} !== {c == 1, c == 3, 1'b0, c >= 1 && c <= 3}) begin
        n_fail++; $display("FAIL fetch_strobes c=%0d got=%b want=%b", c,
          {b1.mem_en, b1.if_ack, b1.dm_ack, b1.busy}, {c == 1, c == 3, 1'b0, c >= 1 && c <= 3});
      end
      if (c == 1) begin
        n_checks++;
        if ({b1.mem_we, b1.mem_be, b1.mem_addr} !== {1'b0, 4'hF, 32'h100}) begin
          n_fail++; $display("FAIL fetch_issue got=%h want=%h",
                             {b1.mem_we, b1.mem_be, b1.mem_addr}, {1'b0, 4'hF, 32'h100});
        end
      end
      if (c == 3) begin
        n_checks++;
        if (b1.if_rdata !== 32'hDEADBEEF) begin
          n_fail++; $display("FAIL fetch_rdata got=%h want=deadbeef", b1.if_rdata);
        end
      end
      @(posedge clk); #1;
      if (c == 3) b1.if_req = 0;
    end
  endtask

  task automatic test_tie();
    pulse_reset();
    @(posedge clk); #1;
    b1.if_req = 1; b1.if_addr = 32'h104;
    b1.dm_req = 1; b1.dm_we = 0; b1.dm_be = 4'hC; b1.dm_addr = 32'h80;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      n_checks++;
      if ({b1.if_ack, b1.dm_ack} !== {c == 7 || c == 15, c == 3 || c == 11}) begin
        n_fail++; $display("FAIL tie_acks c=%0d got=%b want=%b", c,
          {b1.if_ack, b1.dm_ack}, {c == 7 || c == 15, c == 3 || c == 11});
      end
      if (c == 1) begin
        n_checks++;
        if ({b1.mem_en, b1.mem_be, b1.mem_addr} !== {1'b1, 4'hC, 32'h80}) begin
          n_fail++; $display("FAIL tie_issue_dm got=%h want=%h",
                             {b1.mem_en, b1.mem_be, b1.mem_addr}, {1'b1, 4'hC, 32'h80});
        end
      end
      if (c == 5) begin
        n_checks++;
        if ({b1.mem_en, b1.mem_we, b1.mem_be, b1.mem_addr} !== {2'b10, 4'hF, 32'h104}) begin
          n_fail++; $display("FAIL tie_issue_if got=%h want=%h",
                             {b1.mem_en, b1.mem_we, b1.mem_be, b1.mem_addr}, {2'b10, 4'hF, 32'h104});
        end
      end
      if (c == 3) begin
        n_checks++;
        if (b1.dm_rdata !== 32'hA5A5_0080) begin
          n_fail++; $display("FAIL tie_dm_rdata got=%h want=a5a50080", b1.dm_rdata);
        end
      end
      if (c == 7) begin
        n_checks++;
        if ({b1.if_rdata, b1.dm_rdata} !== {32'hA5A5_0104, 32'hA5A5_0080}) begin
          n_fail++; $display("FAIL tie_if_rdata got=%h want=a5a50104a5a50080", {b1.if_rdata, b1.dm_rdata});
        end
      end
      @(posedge clk); #1;
      if (c == 15) begin b1.if_req = 0; b1.dm_req = 0; end
    end
  endtask

  task automatic test_write();
    @(posedge clk); #1;
    b1.dm_req = 1; b1.dm_we = 1; b1.dm_be = 4'b0011; b1.dm_addr = 32'h40; b1.dm_wdata = 32'h1234;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_checks++;
      if ({b1.dm_ack, b1.if_ack} !== {c == 3, 1'b0}) begin
        n_fail++; $display("FAIL wr_acks c=%0d got=%b want=%b", c, {b1.dm_ack, b1.if_ack}, {c == 3, 1'b0});
      end
      if (c == 1 || c == 2) begin
        n_checks++;
        if ({b1.mem_en, b1.mem_we, b1.mem_be, b1.mem_addr, b1.mem_wdata} !==
            {c == 1, c == 1, 4'b0011, 32'h40, 32'h1234}) begin
          n_fail++; $display("FAIL wr_membus c=%0d got=%h want=%h", c,
            {b1.mem_en, b1.mem_we, b1.mem_be, b1.mem_addr, b1.mem_wdata},
            {c == 1, c == 1, 4'b0011, 32'h40, 32'h1234});
        end
      end
      if (c == 3) begin
        n_checks++;
        if ({b1.dm_rdata, b1.if_rdata} !== {32'h0, 32'hA5A5_0104}) begin
          n_fail++; $display("FAIL wr_rdata got=%h want=00000000a5a50104", {b1.dm_rdata, b1.if_rdata});
        end
      end
      @(posedge clk); #1;
      if (c == 3) begin b1.dm_req = 0; b1.dm_we = 0; end
    end
  endtask

  task automatic test_drop();
    @(posedge clk); #1;
    b1.dm_req = 1; b1.dm_we = 0; b1.dm_be = 4'hF; b1.dm_addr = 32'h44;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_checks++;
      if (b1.dm_ack !== (c == 3)) begin
        n_fail++; $display("FAIL drop_ack c=%0d got=%b want=%b", c, b1.dm_ack, c == 3);
      end
      if (c == 3) begin
        n_checks++;
        if (b1.dm_rdata !== 32'hA5A5_0044) begin
          n_fail++; $display("FAIL drop_rdata got=%h want=a5a50044", b1.dm_rdata);
        end
      end
      @(posedge clk); #1;
      if (c == 0) b1.dm_req = 0;
    end
  endtask

  task automatic test_addr_change();
    @(posedge clk); #1;
    b1.if_req = 1; b1.if_addr = 32'h100;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c >= 1 && c <= 3) begin
        n_checks++;
        if (b1.mem_addr !== 32'h100) begin
          n_fail++; $display("FAIL addrchg_mem_addr c=%0d got=%h want=00000100", c, b1.mem_addr);
        end
      end
      if (c == 3) begin
        n_checks++;
        if ({b1.if_ack, b1.if_rdata} !== {1'b1, 32'hDEADBEEF}) begin
          n_fail++; $display("FAIL addrchg_ack got=%h want=1deadbeef", {b1.if_ack, b1.if_rdata});
        end
      end
      @(posedge clk); #1;
      if (c == 1) b1.if_addr = 32'h200;
      if (c == 3) begin b1.if_req = 0; b1.if_addr = 32'h0; end
    end
  endtask

  task automatic test_lat3();
    @(posedge clk); #1;
    b3.dm_req = 1; b3.dm_we = 0; b3.dm_be = 4'hF; b3.dm_addr = 32'h300;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_checks++;
      if ({b3.busy, b3.mem_en, b3.dm_ack, b3.if_ack} !== {c >= 1 && c <= 5, c == 1, c == 5, 1'b0}) begin
        n_fail++; $display("FAIL lat3_strobes c=%0d got=%b want=%b", c,
          {b3.busy, b3.mem_en, b3.dm_ack, b3.if_ack}, {c >= 1 && c <= 5, c == 1, c == 5, 1'b0});
      end
      if (c == 5) begin
        n_checks++;
        if (b3.dm_rdata !== 32'hA5A5_0300) begin
          n_fail++; $display("FAIL lat3_rdata got=%h want=a5a50300", b3.dm_rdata);
        end
      end
      @(posedge clk); #1;
      if (c == 5) b3.dm_req = 0;
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    b1.if_req = 1; b1.if_addr = 32'h104;
    repeat (2) @(posedge clk);
    #1 rst = 1;  // cycle 2, WAIT
    b1.if_req = 0;
    #1;
    n_checks++;
    if ({b1.mem_en, b1.mem_we, b1.if_ack, b1.dm_ack, b1.busy, b1.mem_be, b1.mem_addr, b1.mem_wdata} !== 73'h0) begin
      n_fail++; $display("FAIL rstmid_outputs got=%h want=0",
        {b1.mem_en, b1.mem_we, b1.if_ack, b1.dm_ack, b1.busy, b1.mem_be, b1.mem_addr, b1.mem_wdata});
    end
    n_checks++;
    if ({b1.if_rdata, b1.dm_rdata} !== 64'h0) begin
      n_fail++; $display("FAIL rstmid_rdata got=%h want=0", {b1.if_rdata, b1.dm_rdata});
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if ({b1.if_ack, b1.dm_ack, b1.busy} !== 3'b0) begin
        n_fail++; $display("FAIL rstmid_hold c=%0d got=%b want=000", c, {b1.if_ack, b1.dm_ack, b1.busy});
      end
    end
    @(posedge clk); #1 rst = 0;
    @(posedge clk); #1;
    b1.if_req = 1; b1.if_addr = 32'h100;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_checks++;
      if ({b1.if_ack, b1.dm_ack} !== {c == 3, 1'b0}) begin
        n_fail++; $display("FAIL rstmid_after_ack c=%0d got=%b want=%b", c, {b1.if_ack, b1.dm_ack}, {c == 3, 1'b0});
      end
      if (c == 3) begin
        n_checks++;
        if (b1.if_rdata !== 32'hDEADBEEF) begin
          n_fail++; $display("FAIL rstmid_after_rdata got=%h want=deadbeef", b1.if_rdata);
        end
      end
      @(posedge clk); #1;
      if (c == 3) b1.if_req = 0;
    end
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    b1.if_req = 1; b1.if_addr = 32'h108;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_checks++;
      if ({b1.if_ack, b1.mem_en} !== {c == 3 || c == 7, c == 1 || c == 5}) begin
        n_fail++; $display("FAIL b2b c=%0d got=%b want=%b", c,
          {b1.if_ack, b1.mem_en}, {c == 3 || c == 7, c == 1 || c == 5});
      end
      if (c == 7) begin
        n_checks++;
        if (b1.if_rdata !== 32'hA5A5_0108) begin
          n_fail++; $display("FAIL b2b_rdata got=%h want=a5a50108", b1.if_rdata);
        end
      end
      @(posedge clk); #1;
      if (c == 7) b1.if_req = 0;
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_tie();
    test_write();
    test_drop();
    test_addr_change();
    test_lat3();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
